// File: rtl/medidor_pwm_if.sv
// Signal bundle between a PWM source and the medidor_pwm receiver.
// The source drives the PWM line; the receiver returns its measurements and status.
interface medidor_pwm_if #(
  parameter int LARGURA_CONT = 21
);
  logic                    pwm_in;
  logic [LARGURA_CONT-1:0] largura;
  logic [LARGURA_CONT-1:0] periodo;
  logic                    posicao;
  logic                    pronto;
  logic                    erro_timeout;
  logic [1:0]              db_estado;

  modport master (
    output pwm_in,
    input  largura, periodo, posicao, pronto, erro_timeout, db_estado
  );

  modport slave (
    input  pwm_in,
    output largura, periodo, posicao, pronto, erro_timeout, db_estado
  );
endinterface

// File: rtl/medidor_pwm.sv
// Servo PWM receiver: measures the high time and period of pwm_in in clock cycles,
// classifies the pulse as parado/gira and flags a missing signal with erro_timeout.
module medidor_pwm #(
  parameter int LARGURA_CONT = 21,
  parameter int LIMIAR       = 82500,
  parameter int TIMEOUT      = 2000000
) (
  input  logic         clock,
  input  logic         reset,
  medidor_pwm_if.slave bus
);
  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ALTO   = 2'd1,
    BAIXO  = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] TIMEOUT_C = LARGURA_CONT'(TIMEOUT);
  localparam logic [LARGURA_CONT-1:0] LIMIAR_C  = LARGURA_CONT'(LIMIAR);
  localparam logic [LARGURA_CONT-1:0] UM        = LARGURA_CONT'(1);

  estado_t                 estado_q, estado_d;
  logic                    sync1_q, sync2_q, sync3_q;
  logic                    subida, descida, periodo_sat;
  logic [LARGURA_CONT-1:0] cont_alto_q, cont_alto_d;
  logic [LARGURA_CONT-1:0] cont_periodo_q, cont_periodo_d;
  logic [LARGURA_CONT-1:0] largura_q, largura_d;
  logic [LARGURA_CONT-1:0] periodo_q, periodo_d;
  logic                    posicao_q, posicao_d;
  logic                    pronto_q, pronto_d;

  // The chain resets to 1 so a pulse already high at reset release never looks
  // like a rising edge; only a genuine low-to-high transition starts a measurement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= bus.pwm_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign subida      = sync2_q & ~sync3_q;
  assign descida     = ~sync2_q & sync3_q;
  assign periodo_sat = (cont_periodo_q == TIMEOUT_C);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ESPERA;
    end else begin
      estado_q <= estado_d;
    end
  end

  // An edge always takes priority over the timeout test in the same cycle.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA: if (subida) estado_d = ALTO;
      ALTO: begin
        if (descida) estado_d = BAIXO;
        else if (periodo_sat) estado_d = ERRO;
      end
      BAIXO: begin
        if (subida) estado_d = ALTO;
        else if (periodo_sat) estado_d = ERRO;
      end
      ERRO: if (subida) estado_d = ALTO;
    endcase
  end

  always_comb begin
    cont_alto_d    = cont_alto_q;
    cont_periodo_d = cont_periodo_q;
    largura_d      = largura_q;
    periodo_d      = periodo_q;
    posicao_d      = posicao_q;
    pronto_d       = 1'b0;
    case (estado_q)
      ESPERA, ERRO: begin
        if (subida) begin
          cont_alto_d    = UM;
          cont_periodo_d = UM;
        end
      end
      ALTO: begin
        if (!descida && cont_alto_q != TIMEOUT_C) cont_alto_d = cont_alto_q + UM;
        if (!periodo_sat) cont_periodo_d = cont_periodo_q + UM;
      end
      BAIXO: begin
        if (subida) begin
          largura_d      = cont_alto_q;
          periodo_d      = cont_periodo_q;
          posicao_d      = (cont_alto_q >= LIMIAR_C);
          pronto_d       = 1'b1;
          cont_alto_d    = UM;
          cont_periodo_d = UM;
        end else if (!periodo_sat) begin
          cont_periodo_d = cont_periodo_q + UM;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_alto_q    <= '0;
      cont_periodo_q <= '0;
      largura_q      <= '0;
      periodo_q      <= '0;
      posicao_q      <= 1'b0;
      pronto_q       <= 1'b0;
    end else begin
      cont_alto_q    <= cont_alto_d;
      cont_periodo_q <= cont_periodo_d;
      largura_q      <= largura_d;
      periodo_q      <= periodo_d;
      posicao_q      <= posicao_d;
      pronto_q       <= pronto_d;
    end
  end

  assign bus.largura      = largura_q;
  assign bus.periodo      = periodo_q;
  assign bus.posicao      = posicao_q;
  assign bus.pronto       = pronto_q;
  assign bus.erro_timeout = (estado_q == ERRO);
  assign bus.db_estado    = estado_q;
endmodule

// File: tb/tb_medidor_pwm.sv
// Scoreboard bench for medidor_pwm: dutA runs time-scaled servo waveforms (1/100),
// dutB uses a short TIMEOUT to exercise error, reset and boundary behaviour.
module tb_medidor_pwm;
  localparam int LIMIAR_A  = 825;
  localparam int TIMEOUT_A = 20000;
  localparam int TIMEOUT_B = 50;

  typedef struct {
    int largura;
    int periodo;
    int posicao;
    int tolL;
    int tolP;
  } exp_t;

  logic clock = 1'b0;
  logic resetA, resetB;
  logic pwmA, pwmB;
  int   checks = 0;
  int   errors = 0;
  int   erroCyclesB = 0;
  exp_t expA[$];
  exp_t expB[$];
  exp_t curA, curB;

  always #5 clock = ~clock;

  medidor_pwm_if #(.LARGURA_CONT(21)) ifA ();
  medidor_pwm_if #(.LARGURA_CONT(21)) ifB ();
  assign ifA.pwm_in = pwmA;
  assign ifB.pwm_in = pwmB;

  medidor_pwm #(.LARGURA_CONT(21), .LIMIAR(LIMIAR_A), .TIMEOUT(TIMEOUT_A)) dutA (
    .clock(clock), .reset(resetA), .bus(ifA)
  );
  medidor_pwm #(.LARGURA_CONT(21), .LIMIAR(82500), .TIMEOUT(TIMEOUT_B)) dutB (
    .clock(clock), .reset(resetB), .bus(ifB)
  );

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    checks++;
    if (actual > expected + tol || actual < expected - tol) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d) at %0t", name, actual, expected, tol, $time);
    end
  endtask

  task automatic pushExp(input int sel, input int l, input int p, input int pos, input int tolL, input int tolP);
    exp_t e;
    e.largura = l;
    e.periodo = p;
    e.posicao = pos;
    e.tolL    = tolL;
    e.tolP    = tolP;
    if (sel == 0) expA.push_back(e);
    else expB.push_back(e);
  endtask

  task automatic setPwm(input int sel, input logic v);
    if (sel == 0) pwmA = v;
    else pwmB = v;
  endtask

  // One clock-aligned period: high for h sampled edges, low for p-h; entered and left at posedge+1.
  task automatic applyStimulus(input int sel, input int h, input int p, input int expPos, input int tolP);
    pushExp(sel, h, p, expPos, 0, tolP);
    setPwm(sel, 1'b1);
    repeat (h) @(posedge clock);
    #1 setPwm(sel, 1'b0);
    repeat (p - h) @(posedge clock);
    #1;
  endtask

  // Edges land at random points up to ~2 cycles late, so each measurement may shift by one cycle.
  task automatic applyJitter(input int h, input int p);
    int a, b;
    a = $urandom_range(0, 16);
    if (a >= 9) a++;
    b = $urandom_range(0, 16);
    if (b >= 9) b++;
    pushExp(0, h, p, 0, 1, 1);
    #(a) pwmA = 1'b1;
    #(h * 10 - a + b) pwmA = 1'b0;
    #(p * 10 - h * 10 - b);
  endtask

  // Each pronto is matched against the oldest outstanding expectation.
  always @(negedge clock) begin
    if (ifA.pronto) begin
      if (expA.size() == 0) begin
        checkOutput("A unexpected pronto", 1, 0, 0);
      end else begin
        curA = expA.pop_front();
        checkOutput("A largura", int'(ifA.largura), curA.largura, curA.tolL);
        checkOutput("A periodo", int'(ifA.periodo), curA.periodo, curA.tolP);
        checkOutput("A posicao", int'(ifA.posicao), curA.posicao, 0);
      end
    end
  end

  always @(negedge clock) begin
    if (ifB.erro_timeout) erroCyclesB++;
    if (ifB.pronto) begin
      if (expB.size() == 0) begin
        checkOutput("B unexpected pronto", 1, 0, 0);
      end else begin
        curB = expB.pop_front();
        checkOutput("B largura", int'(ifB.largura), curB.largura, curB.tolL);
        checkOutput("B periodo", int'(ifB.periodo), curB.periodo, curB.tolP);
        checkOutput("B posicao", int'(ifB.posicao), curB.posicao, 0);
      end
    end
  end

  initial begin
    int seen, cyc, snap;
    resetA = 1'b1;
    resetB = 1'b1;
    pwmA   = 1'b1;
    pwmB   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("A reset largura", int'(ifA.largura), 0, 0);
    checkOutput("A reset periodo", int'(ifA.periodo), 0, 0);
    checkOutput("A reset posicao", int'(ifA.posicao), 0, 0);
    checkOutput("A reset pronto", int'(ifA.pronto), 0, 0);
    checkOutput("A reset erro", int'(ifA.erro_timeout), 0, 0);
    checkOutput("A reset estado", int'(ifA.db_estado), 0, 0);
    checkOutput("B reset largura", int'(ifB.largura), 0, 0);
    checkOutput("B reset periodo", int'(ifB.periodo), 0, 0);
    checkOutput("B reset posicao", int'(ifB.posicao), 0, 0);
    checkOutput("B reset pronto", int'(ifB.pronto), 0, 0);
    checkOutput("B reset erro", int'(ifB.erro_timeout), 0, 0);
    checkOutput("B reset estado", int'(ifB.db_estado), 0, 0);
    resetA = 1'b0;
    resetB = 1'b0;

    fork
      begin
        // Partial pulse present at reset must be ignored.
        repeat (50) @(posedge clock);
        #1 pwmA = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        applyStimulus(0, 750, 10000, 0, 0);
        applyStimulus(0, 750, 10000, 0, 0);
        applyStimulus(0, 750, 10000, 0, 0);
        applyStimulus(0, 900, 2000, 1, 0);
        applyStimulus(0, 825, 2000, 1, 0);
        applyStimulus(0, 824, 2000, 0, 1);
        applyJitter(750, 10000);
        applyJitter(750, 10000);
        pwmA = 1'b1;
        repeat (20) @(posedge clock);
        #1 pwmA = 1'b0;
        repeat (30) @(posedge clock);
        #1;
      end
      begin
        repeat (5) @(posedge clock);
        #1 pwmB = 1'b1;
        seen = 0;
        cyc  = 0;
        for (int c = 1; c <= 70 && seen == 0; c++) begin
          @(posedge clock);
          #1;
          if (ifB.erro_timeout) begin
            seen = 1;
            cyc  = c;
          end
        end
        checkOutput("B timeout raised", seen, 1, 0);
        checkOutput("B timeout latency", cyc, TIMEOUT_B + 2, 1);
        checkOutput("B estado erro", int'(ifB.db_estado), 3, 0);
        repeat ((cyc > 0) ? 60 - cyc : 1) @(posedge clock);
        #1 pwmB = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        checkOutput("B erro holds", int'(ifB.erro_timeout), 1, 0);
        applyStimulus(1, 3, 10, 0, 0);
        checkOutput("B erro cleared", int'(ifB.erro_timeout), 0, 0);
        checkOutput("B estado baixo", int'(ifB.db_estado), 2, 0);
        applyStimulus(1, 3, 10, 0, 0);

        // Reset lands in ALTO; the interrupted period must vanish.
        pwmB = 1'b1;
        repeat (4) @(posedge clock);
        #1 resetB = 1'b1;
        #1;
        checkOutput("B midreset largura", int'(ifB.largura), 0, 0);
        checkOutput("B midreset periodo", int'(ifB.periodo), 0, 0);
        checkOutput("B midreset posicao", int'(ifB.posicao), 0, 0);
        checkOutput("B midreset pronto", int'(ifB.pronto), 0, 0);
        checkOutput("B midreset erro", int'(ifB.erro_timeout), 0, 0);
        checkOutput("B midreset estado", int'(ifB.db_estado), 0, 0);
        repeat (2) @(posedge clock);
        #1 resetB = 1'b0;
        repeat (3) @(posedge clock);
        #1 pwmB = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        applyStimulus(1, 3, 10, 0, 0);

        pushExp(1, 3, 10, 0, 0, 0);
        pwmB = 1'b1;
        for (int e = 1; e <= 3; e++) begin
          @(posedge clock);
          #1;
          checkOutput("B pronto latency", int'(ifB.pronto), (e == 3) ? 1 : 0, 0);
        end
        pwmB = 1'b0;
        repeat (7) @(posedge clock);
        #1;

        for (int k = 0; k < 4; k++) applyStimulus(1, 1, 2, 0, 0);
        snap = erroCyclesB;
        applyStimulus(1, 3, TIMEOUT_B, 0, 0);
        applyStimulus(1, 3, 10, 0, 0);
        pwmB = 1'b1;
        repeat (3) @(posedge clock);
        #1 pwmB = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        checkOutput("B no erro at boundary", erroCyclesB - snap, 0, 0);
      end
    join

    repeat (10) @(posedge clock);
    #1;
    checkOutput("A missing pronto", expA.size(), 0, 0);
    checkOutput("B missing pronto", expB.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
